// File: rtl/alu_dec_pkg.sv
// Shared opcode, funct, ALU-control and ALUOp encodings for the MIPS EX-stage decoder and ALU.
// Optional logic-immediate support is selected by the ALU_DEC_IMM_LOGIC_EN macro in the users.
package alu_dec_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_NOR   = 6'b100111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_LOGIC = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    jump;
        logic    branch;
        logic    bne;
        logic    mem_read;
        logic    mem_to_reg;
        logic    mem_write;
        logic    alu_src;
        logic    reg_write;
        logic    reg_dst;
        alu_op_e alu_op;
    } ctrl_t;

    // Unknown R-type functs fall back to add so a stray encoding never stalls the datapath.
    function automatic logic [3:0] alu_ctrl_from_funct(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            FN_NOR:  return ALU_NOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_dec_core.sv
// Purely combinational WIDTH-bit ALU: selects and/or/add/sub/slt/nor from a 4-bit control code.
module alu_dec_core
    import alu_dec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        // NOTE: default assignment first so every path drives result and no latch is inferred.
        result = '0;
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_NOR: result = ~(a | b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_decode_unit.sv
// Main-control decoder, ALU-control decoder and registered 32-bit ALU for the MIPS EX stage.
// Define ALU_DEC_IMM_LOGIC_EN to decode andi/ori with a zero-extended 16-bit immediate.
module alu_decode_unit
    import alu_dec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic [WIDTH-1:0] imm_ext,
    output logic             jump,
    output logic             branch,
    output logic             bne,
    output logic             mem_read,
    output logic             mem_to_reg,
    output logic             mem_write,
    output logic             alu_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic [1:0]       alu_op,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q
);

    ctrl_t            w_ctrl;
    logic [3:0]       w_alu_ctrl;
    logic [WIDTH-1:0] w_operand_b;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    always_comb begin
        w_ctrl        = '0;
        w_ctrl.alu_op = ALUOP_ADD;
        case (opcode)
            OP_RTYPE: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_read   = 1'b1;
            end
            OP_SW: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                w_ctrl.branch = 1'b1;
                w_ctrl.alu_op = ALUOP_SUB;
            end
            OP_BNE: begin
                w_ctrl.bne    = 1'b1;
                w_ctrl.alu_op = ALUOP_SUB;
            end
            OP_ADDI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OP_J: begin
                w_ctrl.jump = 1'b1;
            end
`ifdef ALU_DEC_IMM_LOGIC_EN
            OP_ANDI, OP_ORI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALUOP_LOGIC;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_alu_ctrl = ALU_ADD;
        case (w_ctrl.alu_op)
            ALUOP_ADD:   w_alu_ctrl = ALU_ADD;
            ALUOP_SUB:   w_alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: w_alu_ctrl = alu_ctrl_from_funct(funct);
`ifdef ALU_DEC_IMM_LOGIC_EN
            ALUOP_LOGIC: w_alu_ctrl = opcode[0] ? ALU_OR : ALU_AND;
`else
            // Unreachable without logic-immediate support; add keeps the select defined.
            ALUOP_LOGIC: w_alu_ctrl = ALU_ADD;
`endif
            default:     w_alu_ctrl = ALU_ADD;
        endcase
    end

`ifdef ALU_DEC_IMM_LOGIC_EN
    // andi/ori take the raw low half of the immediate, not the sign-extended value.
    assign w_operand_b = (w_ctrl.alu_op == ALUOP_LOGIC) ? {{(WIDTH-16){1'b0}}, imm_ext[15:0]}
                                                        : (w_ctrl.alu_src ? imm_ext : rt_data);
`else
    assign w_operand_b = w_ctrl.alu_src ? imm_ext : rt_data;
`endif

    alu_dec_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .ctrl   (w_alu_ctrl),
        .a      (rs_data),
        .b      (w_operand_b),
        .result (w_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep registered state race-free across always_ff blocks.
            r_result <= w_result;
            r_zero   <= (w_result == '0);
        end
    end

    assign jump       = w_ctrl.jump;
    assign branch     = w_ctrl.branch;
    assign bne        = w_ctrl.bne;
    assign mem_read   = w_ctrl.mem_read;
    assign mem_to_reg = w_ctrl.mem_to_reg;
    assign mem_write  = w_ctrl.mem_write;
    assign alu_src    = w_ctrl.alu_src;
    assign reg_write  = w_ctrl.reg_write;
    assign reg_dst    = w_ctrl.reg_dst;
    assign alu_op     = w_ctrl.alu_op;
    assign alu_ctrl   = w_alu_ctrl;
    assign result_q   = r_result;
    assign zero_q     = r_zero;

endmodule

// File: tb/tb_alu_decode_unit.sv
// Self-checking bench for alu_decode_unit: directed cases plus randomized instructions vs a reference model.
// Honours ALU_DEC_IMM_LOGIC_EN the same way as the design.
module tb_alu_decode_unit;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm_ext;
    logic        jump, branch, bne, mem_read, mem_to_reg, mem_write;
    logic        alu_src, reg_write, reg_dst;
    logic [1:0]  alu_op;
    logic [3:0]  alu_ctrl;
    logic [31:0] result_q;
    logic        zero_q;

    int n_cmp = 0;
    int n_err = 0;

    // Expected control word per opcode: {jump,branch,bne,mem_read,mem_to_reg,mem_write,alu_src,reg_write,reg_dst,alu_op}
    logic [10:0] ctrl_tbl [0:63];

    alu_decode_unit #(
        .WIDTH (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .imm_ext    (imm_ext),
        .jump       (jump),
        .branch     (branch),
        .bne        (bne),
        .mem_read   (mem_read),
        .mem_to_reg (mem_to_reg),
        .mem_write  (mem_write),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .alu_op     (alu_op),
        .alu_ctrl   (alu_ctrl),
        .result_q   (result_q),
        .zero_q     (zero_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_logic_imm(input logic [5:0] op);
`ifdef ALU_DEC_IMM_LOGIC_EN
        return (op == 6'd12) || (op == 6'd13);
`else
        return 1'b0;
`endif
    endfunction

    // Expected ALU select from the instruction meaning.
    function automatic logic [3:0] model_alu_ctrl(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0) begin
            if (fn == 6'd32) return 4'd2;
            if (fn == 6'd34) return 4'd6;
            if (fn == 6'd36) return 4'd0;
            if (fn == 6'd37) return 4'd1;
            if (fn == 6'd42) return 4'd7;
            if (fn == 6'd39) return 4'd12;
            return 4'd2;
        end
        if (op == 6'd4 || op == 6'd5) return 4'd6;
        if (is_logic_imm(op)) return (op == 6'd13) ? 4'd1 : 4'd0;
        return 4'd2;
    endfunction

    // Expected result from instruction semantics (what the EX stage should compute).
    function automatic logic [31:0] model_result(input logic [5:0] op, input logic [5:0] fn,
                                                 input logic [31:0] a, input logic [31:0] rt,
                                                 input logic [31:0] imm);
        logic [31:0] zimm;
        zimm = imm & 32'h0000_FFFF;
        if (op == 6'd0) begin
            if (fn == 6'd34) return a - rt;
            if (fn == 6'd36) return a & rt;
            if (fn == 6'd37) return a | rt;
            if (fn == 6'd39) return ~(a | rt);
            if (fn == 6'd42) return (int'(a) < int'(rt)) ? 32'd1 : 32'd0;
            return a + rt;
        end
        if (op == 6'd35 || op == 6'd43 || op == 6'd8) return a + imm;
        if (op == 6'd4 || op == 6'd5) return a - rt;
        if (is_logic_imm(op)) return (op == 6'd13) ? (a | zimm) : (a & zimm);
        return a + rt;
    endfunction

    function automatic logic [10:0] dut_ctrl_word();
        return {jump, branch, bne, mem_read, mem_to_reg, mem_write,
                alu_src, reg_write, reg_dst, alu_op};
    endfunction

    // Drive one instruction, check decode combinationally, then the registered result after the edge.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] rt, input logic [31:0] imm);
        logic [31:0] exp_res;
        opcode  = op;
        funct   = fn;
        rs_data = a;
        rt_data = rt;
        imm_ext = imm;
        exp_res = model_result(op, fn, a, rt, imm);
        #1;
        check({tag, ".ctrl"}, {21'd0, dut_ctrl_word()}, {21'd0, ctrl_tbl[op]});
        check({tag, ".alu_ctrl"}, {28'd0, alu_ctrl}, {28'd0, model_alu_ctrl(op, fn)});
        @(posedge clk);
        #1;
        check({tag, ".result_q"}, result_q, exp_res);
        check({tag, ".zero_q"}, {31'd0, zero_q}, {31'd0, (exp_res == 32'd0)});
    endtask

    initial begin
        logic [5:0]  op_pool [0:9];
        logic [5:0]  fn_pool [0:6];
        logic [5:0]  r_op, r_fn;
        logic [31:0] r_a, r_b, r_imm;

        for (int i = 0; i < 64; i++) ctrl_tbl[i] = 11'd0;
        ctrl_tbl[6'd0]  = 11'b000_000_011_10;
        ctrl_tbl[6'd35] = 11'b000_110_110_00;
        ctrl_tbl[6'd43] = 11'b000_001_100_00;
        ctrl_tbl[6'd4]  = 11'b010_000_000_01;
        ctrl_tbl[6'd5]  = 11'b001_000_000_01;
        ctrl_tbl[6'd8]  = 11'b000_000_110_00;
        ctrl_tbl[6'd2]  = 11'b100_000_000_00;
`ifdef ALU_DEC_IMM_LOGIC_EN
        ctrl_tbl[6'd12] = 11'b000_000_110_11;
        ctrl_tbl[6'd13] = 11'b000_000_110_11;
`endif
        op_pool = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd2, 6'd12, 6'd13, 6'd63};
        fn_pool = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39, 6'd0};

        opcode = 6'd0; funct = 6'd0; rs_data = 32'd0; rt_data = 32'd0; imm_ext = 32'd0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("reset.result_q", result_q, 32'd0);
        check("reset.zero_q", {31'd0, zero_q}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_op("r_add", 6'd0, 6'd32, 32'd7, 32'd5, 32'd0);
        run_op("slt_neg", 6'd0, 6'd42, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_op("slt_swap", 6'd0, 6'd42, 32'd1, 32'hFFFF_FFFF, 32'd0);
        run_op("lw", 6'd35, 6'd0, 32'h100, 32'd0, 32'hFFFF_FFFC);
        run_op("beq", 6'd4, 6'd0, 32'd9, 32'd9, 32'd0);
        run_op("bne", 6'd5, 6'd0, 32'd9, 32'd9, 32'd0);
        run_op("jump", 6'd2, 6'd0, 32'd3, 32'd4, 32'd0);
        run_op("illegal", 6'd63, 6'd32, 32'd1, 32'd2, 32'd0);
        run_op("r_nor", 6'd0, 6'd39, 32'h0F0F_0000, 32'h0000_00F0, 32'd0);
        run_op("r_badfn", 6'd0, 6'd1, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_op("ori", 6'd13, 6'd0, 32'hF0, 32'd0, 32'hFFFF_800F);
        run_op("andi", 6'd12, 6'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_800F);

        // Reset asserted away from any clock edge must act immediately.
        run_op("pre_rst", 6'd0, 6'd32, 32'd7, 32'd5, 32'd0);
        #2 reset = 1'b1;
        #1;
        check("midrst.result_q", result_q, 32'd0);
        check("midrst.zero_q", {31'd0, zero_q}, 32'd1);
        opcode = 6'd35;
        #1;
        check("midrst.decode", {21'd0, dut_ctrl_word()}, {21'd0, ctrl_tbl[6'd35]});
        @(posedge clk);
        #1;
        check("midrst.hold", result_q, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("post_rst", 6'd0, 6'd34, 32'd100, 32'd58, 32'd0);

        for (int i = 0; i < 300; i++) begin
            r_op = op_pool[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) r_op = 6'($urandom());
            r_fn = fn_pool[$urandom_range(0, 6)];
            if ($urandom_range(0, 5) == 0) r_fn = 6'($urandom());
            r_a   = $urandom();
            r_b   = ($urandom_range(0, 3) == 0) ? r_a : $urandom();
            r_imm = $urandom();
            if ($urandom_range(0, 3) == 0) begin
                r_a = $urandom_range(0, 15);
                r_b = $urandom_range(0, 15);
            end
            run_op("rand", r_op, r_fn, r_a, r_b, r_imm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
